// File: rtl/transition_scheduler.sv
// ============================================================================
// transition_scheduler
// ----------------------------------------------------------------------------
// Decides when playback moves from the active segment to the other one.
// A request names a target segment, a trigger mode and a loop count. A
// request for the segment already playing only reloads the loop count. A
// request for the other segment either swaps at once (IMMEDIATE) or parks
// in WAIT until its trigger fires:
//   SYNC_IDX : the active segment wraps (UPDATE with IDX == CYCLE)
//   SYS_TIME : an UPDATE arrives with SYS_TIME >= the requested time
//   GPIO     : a rising edge on the selected GPIO_IN pin
// While IDLE, the wraps of the active segment are counted. STOP is raised
// once the requested number of loops has been played.
//
// Ports
//   CLK          in   system clock, rising edge
//   RESET        in   synchronous active-high reset
//   SYS_TIME     in   64-bit synchronized system time
//   UPDATE       in   playback index advance strobe
//   IDX          in   current playback index   [IDX_WIDTH]
//   CYCLE        in   last valid index         [IDX_WIDTH]
//   GPIO_IN      in   4 synchronized trigger inputs
//   REQ_VALID    in   request valid
//   REQ_READY    out  request accepted when high (IDLE)
//   REQ_SEGMENT  in   target segment
//   REQ_MODE     in   0 IMMEDIATE, 1 SYNC_IDX, 2 SYS_TIME, 3 GPIO, 4-7 invalid
//   REQ_VALUE    in   target time (SYS_TIME) or pin select [1:0] (GPIO)
//   REQ_REP      in   loops minus one, 16'hFFFF = infinite
//   SEGMENT      out  active segment
//   SWAP         out  one-cycle pulse when SEGMENT changes
//   STOP         out  finite loop count exhausted
//   PENDING      out  a request waits for its trigger (WAIT)
//   ERR          out  one-cycle pulse on an accepted invalid-mode request
// ============================================================================
module transition_scheduler #(
    parameter int IDX_WIDTH = 15
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [63:0]          SYS_TIME,
    input  logic                 UPDATE,
    input  logic [IDX_WIDTH-1:0] IDX,
    input  logic [IDX_WIDTH-1:0] CYCLE,
    input  logic [3:0]           GPIO_IN,
    input  logic                 REQ_VALID,
    output logic                 REQ_READY,
    input  logic                 REQ_SEGMENT,
    input  logic [2:0]           REQ_MODE,
    input  logic [63:0]          REQ_VALUE,
    input  logic [15:0]          REQ_REP,
    output logic                 SEGMENT,
    output logic                 SWAP,
    output logic                 STOP,
    output logic                 PENDING,
    output logic                 ERR
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        MODE_IMMEDIATE = 2'd0,
        MODE_SYNC_IDX  = 2'd1,
        MODE_SYS_TIME  = 2'd2,
        MODE_GPIO      = 2'd3
    } mode_t;

    localparam logic [15:0] REP_INFINITE = 16'hFFFF;

    // Control state (reset)
    state_t      state_q,     state_d;
    logic        segment_q,   segment_d;
    logic        swap_q,      swap_d;
    logic        stop_q,      stop_d;
    logic        err_q,       err_d;
    logic [15:0] loop_cnt_q,  loop_cnt_d;
    logic [15:0] rep_q,       rep_d;
    logic [3:0]  gpio_prev_q, gpio_prev_d;

    // Parked request payload (not reset)
    mode_t       pend_mode_q,  pend_mode_d;
    logic [63:0] pend_value_q, pend_value_d;
    logic [15:0] pend_rep_q,   pend_rep_d;

    logic       wrap;
    logic       accept;
    logic       mode_valid;
    logic [3:0] gpio_rise;
    logic       trigger;

    assign wrap       = UPDATE && (IDX == CYCLE);
    assign accept     = REQ_VALID && (state_q == ST_IDLE);
    assign mode_valid = (REQ_MODE[2] == 1'b0);
    assign gpio_rise  = GPIO_IN & ~gpio_prev_q;

    // Trigger of the parked request, only meaningful while in WAIT.
    always_comb begin
        trigger = 1'b0;
        unique case (pend_mode_q)
            MODE_SYNC_IDX: trigger = wrap;
            MODE_SYS_TIME: trigger = UPDATE && (SYS_TIME >= pend_value_q);
            MODE_GPIO:     trigger = gpio_rise[pend_value_q[1:0]];
            default:       trigger = 1'b0;
        endcase
    end

    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch to hold the value.
    always_comb begin
        state_d      = state_q;
        segment_d    = segment_q;
        swap_d       = 1'b0;
        stop_d       = stop_q;
        err_d        = 1'b0;
        loop_cnt_d   = loop_cnt_q;
        rep_d        = rep_q;
        gpio_prev_d  = GPIO_IN;
        pend_mode_d  = pend_mode_q;
        pend_value_d = pend_value_q;
        pend_rep_d   = pend_rep_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    // A wrap coinciding with acceptance is not counted.
                    if (!mode_valid) begin
                        err_d = 1'b1;
                    end else if (REQ_SEGMENT == segment_q) begin
                        loop_cnt_d = '0;
                        rep_d      = REQ_REP;
                        stop_d     = 1'b0;
                    end else if (mode_t'(REQ_MODE[1:0]) == MODE_IMMEDIATE) begin
                        segment_d  = ~segment_q;
                        swap_d     = 1'b1;
                        loop_cnt_d = '0;
                        rep_d      = REQ_REP;
                        stop_d     = 1'b0;
                    end else begin
                        state_d      = ST_WAIT;
                        pend_mode_d  = mode_t'(REQ_MODE[1:0]);
                        pend_value_d = REQ_VALUE;
                        pend_rep_d   = REQ_REP;
                    end
                end else if (wrap && !stop_q && (rep_q != REP_INFINITE)) begin
                    // Counter holds at REP once the last loop has played.
                    if (loop_cnt_q == rep_q) begin
                        stop_d = 1'b1;
                    end else begin
                        loop_cnt_d = loop_cnt_q + 16'd1;
                    end
                end
            end

            ST_WAIT: begin
                // Old segment keeps playing: counter and STOP hold here.
                if (trigger) begin
                    state_d    = ST_IDLE;
                    segment_d  = ~segment_q;
                    swap_d     = 1'b1;
                    loop_cnt_d = '0;
                    rep_d      = pend_rep_q;
                    stop_d     = 1'b0;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, matching the hardware.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            segment_q   <= 1'b0;
            swap_q      <= 1'b0;
            stop_q      <= 1'b0;
            err_q       <= 1'b0;
            loop_cnt_q  <= '0;
            rep_q       <= REP_INFINITE;
            gpio_prev_q <= '0;
        end else begin
            state_q     <= state_d;
            segment_q   <= segment_d;
            swap_q      <= swap_d;
            stop_q      <= stop_d;
            err_q       <= err_d;
            loop_cnt_q  <= loop_cnt_d;
            rep_q       <= rep_d;
            gpio_prev_q <= gpio_prev_d;
        end
    end

    // NOTE: the parked payload needs no reset; it is only read in WAIT and
    // is always written on the edge that enters WAIT.
    always_ff @(posedge CLK) begin
        pend_mode_q  <= pend_mode_d;
        pend_value_q <= pend_value_d;
        pend_rep_q   <= pend_rep_d;
    end

    assign REQ_READY = (state_q == ST_IDLE);
    assign PENDING   = (state_q == ST_WAIT);
    assign SEGMENT   = segment_q;
    assign SWAP      = swap_q;
    assign STOP      = stop_q;
    assign ERR       = err_q;

endmodule

// File: tb/tb_transition_scheduler.sv
// ============================================================================
// tb_transition_scheduler
// Directed scenarios for transition_scheduler. Inputs change 1 ns after the
// rising edge; outputs are compared 1 ns after the edge that updates them.
// ============================================================================
module tb_transition_scheduler;

    localparam int IDX_WIDTH = 15;

    logic                 CLK;
    logic                 RESET;
    logic [63:0]          SYS_TIME;
    logic                 UPDATE;
    logic [IDX_WIDTH-1:0] IDX;
    logic [IDX_WIDTH-1:0] CYCLE;
    logic [3:0]           GPIO_IN;
    logic                 REQ_VALID;
    logic                 REQ_READY;
    logic                 REQ_SEGMENT;
    logic [2:0]           REQ_MODE;
    logic [63:0]          REQ_VALUE;
    logic [15:0]          REQ_REP;
    logic                 SEGMENT;
    logic                 SWAP;
    logic                 STOP;
    logic                 PENDING;
    logic                 ERR;

    int n_pass;
    int n_total;

    transition_scheduler #(.IDX_WIDTH(IDX_WIDTH)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .SYS_TIME    (SYS_TIME),
        .UPDATE      (UPDATE),
        .IDX         (IDX),
        .CYCLE       (CYCLE),
        .GPIO_IN     (GPIO_IN),
        .REQ_VALID   (REQ_VALID),
        .REQ_READY   (REQ_READY),
        .REQ_SEGMENT (REQ_SEGMENT),
        .REQ_MODE    (REQ_MODE),
        .REQ_VALUE   (REQ_VALUE),
        .REQ_REP     (REQ_REP),
        .SEGMENT     (SEGMENT),
        .SWAP        (SWAP),
        .STOP        (STOP),
        .PENDING     (PENDING),
        .ERR         (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Hard time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_req(input logic seg, input logic [2:0] mode,
                             input logic [63:0] value, input logic [15:0] rep);
        REQ_VALID   = 1'b1;
        REQ_SEGMENT = seg;
        REQ_MODE    = mode;
        REQ_VALUE   = value;
        REQ_REP     = rep;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        step();
        step();
        RESET = 1'b0;
        step();
        n_total++; if (SEGMENT !== 1'b0) $display("FAIL rst_segment: got %b want 0", SEGMENT); else n_pass++;
        n_total++; if (SWAP !== 1'b0) $display("FAIL rst_swap: got %b want 0", SWAP); else n_pass++;
        n_total++; if (STOP !== 1'b0) $display("FAIL rst_stop: got %b want 0", STOP); else n_pass++;
        n_total++; if (PENDING !== 1'b0) $display("FAIL rst_pending: got %b want 0", PENDING); else n_pass++;
        n_total++; if (ERR !== 1'b0) $display("FAIL rst_err: got %b want 0", ERR); else n_pass++;
        n_total++; if (REQ_READY !== 1'b1) $display("FAIL rst_ready: got %b want 1", REQ_READY); else n_pass++;
    endtask

    task automatic test_immediate();
        drive_req(1'b1, 3'd0, 64'd0, 16'hFFFF);
        step();
        REQ_VALID = 1'b0;
        n_total++; if (SEGMENT !== 1'b1) $display("FAIL imm_segment: got %b want 1", SEGMENT); else n_pass++;
        n_total++; if (SWAP !== 1'b1) $display("FAIL imm_swap: got %b want 1", SWAP); else n_pass++;
        n_total++; if (REQ_READY !== 1'b1) $display("FAIL imm_ready: got %b want 1", REQ_READY); else n_pass++;
        n_total++; if (PENDING !== 1'b0) $display("FAIL imm_pending: got %b want 0", PENDING); else n_pass++;
        step();
        n_total++; if (SWAP !== 1'b0) $display("FAIL imm_swap_end: got %b want 0", SWAP); else n_pass++;
        n_total++; if (SEGMENT !== 1'b1) $display("FAIL imm_segment_hold: got %b want 1", SEGMENT); else n_pass++;
    endtask

    // Active segment is 1; request segment 0 on the next wrap of CYCLE=9.
    task automatic test_sync_idx();
        CYCLE = 15'd9;
        IDX   = 15'd0;
        drive_req(1'b0, 3'd1, 64'd0, 16'hFFFF);
        step();
        REQ_VALID = 1'b0;
        n_total++; if (PENDING !== 1'b1) $display("FAIL sync_pending: got %b want 1", PENDING); else n_pass++;
        for (int i = 0; i <= 9; i++) begin
            IDX    = i[IDX_WIDTH-1:0];
            UPDATE = 1'b1;
            step();
            UPDATE = 1'b0;
            if (i < 9) begin
                n_total++; if (SWAP !== 1'b0 || PENDING !== 1'b1 || REQ_READY !== 1'b0)
                    $display("FAIL sync_wait_idx%0d: got swap=%b pend=%b ready=%b want 0 1 0", i, SWAP, PENDING, REQ_READY);
                else n_pass++;
            end
        end
        n_total++; if (SWAP !== 1'b1) $display("FAIL sync_swap: got %b want 1", SWAP); else n_pass++;
        n_total++; if (SEGMENT !== 1'b0) $display("FAIL sync_segment: got %b want 0", SEGMENT); else n_pass++;
        n_total++; if (PENDING !== 1'b0 || REQ_READY !== 1'b1)
            $display("FAIL sync_idle: got pend=%b ready=%b want 0 1", PENDING, REQ_READY);
        else n_pass++;
        IDX = 15'd0;
        step();
        n_total++; if (SWAP !== 1'b0) $display("FAIL sync_swap_end: got %b want 0", SWAP); else n_pass++;
    endtask

    // Active segment 0 -> 1 at time 1000; UPDATE whenever SYS_TIME ends in 9.
    task automatic test_sys_time();
        logic swapped;
        logic exp_swap;
        swapped  = 1'b0;
        SYS_TIME = 64'd984;
        drive_req(1'b1, 3'd2, 64'd1000, 16'hFFFF);
        step();
        REQ_VALID = 1'b0;
        n_total++; if (PENDING !== 1'b1) $display("FAIL time_pending: got %b want 1", PENDING); else n_pass++;
        for (int t = 985; t <= 1020 && !swapped; t++) begin
            SYS_TIME = 64'(t);
            UPDATE   = (t % 10 == 9);
            step();
            exp_swap = UPDATE && (t >= 1000);
            UPDATE   = 1'b0;
            n_total++; if (SWAP !== exp_swap)
                $display("FAIL time_swap_t%0d: got %b want %b", t, SWAP, exp_swap);
            else n_pass++;
            if (exp_swap) swapped = 1'b1;
        end
        n_total++; if (SEGMENT !== 1'b1 || PENDING !== 1'b0)
            $display("FAIL time_final: got seg=%b pend=%b want 1 0", SEGMENT, PENDING);
        else n_pass++;
    endtask

    // Active segment 1 -> 0 on a rising edge of GPIO_IN[2].
    task automatic test_gpio();
        GPIO_IN = 4'b0100;
        step();
        step();
        drive_req(1'b0, 3'd3, 64'd2, 16'hFFFF);
        step();
        REQ_VALID = 1'b0;
        n_total++; if (PENDING !== 1'b1) $display("FAIL gpio_pending: got %b want 1", PENDING); else n_pass++;
        step();
        n_total++; if (SWAP !== 1'b0) $display("FAIL gpio_level_held: got %b want 0", SWAP); else n_pass++;
        GPIO_IN = 4'b1111;
        step();
        n_total++; if (SWAP !== 1'b0) $display("FAIL gpio_other_pins: got %b want 0", SWAP); else n_pass++;
        GPIO_IN = 4'b0000;
        step();
        n_total++; if (SWAP !== 1'b0 || PENDING !== 1'b1)
            $display("FAIL gpio_drop: got swap=%b pend=%b want 0 1", SWAP, PENDING);
        else n_pass++;
        GPIO_IN = 4'b0100;
        step();
        n_total++; if (SWAP !== 1'b1) $display("FAIL gpio_swap: got %b want 1", SWAP); else n_pass++;
        n_total++; if (SEGMENT !== 1'b0) $display("FAIL gpio_segment: got %b want 0", SEGMENT); else n_pass++;
        step();
        n_total++; if (SWAP !== 1'b0 || PENDING !== 1'b0)
            $display("FAIL gpio_after: got swap=%b pend=%b want 0 0", SWAP, PENDING);
        else n_pass++;
        GPIO_IN = 4'b0000;
    endtask

    // Swap to segment 1 with REP=2: STOP after the 3rd wrap.
    task automatic test_loop_stop();
        logic exp_stop;
        drive_req(1'b1, 3'd0, 64'd0, 16'd2);
        step();
        REQ_VALID = 1'b0;
        n_total++; if (SWAP !== 1'b1 || STOP !== 1'b0)
            $display("FAIL loop_swap: got swap=%b stop=%b want 1 0", SWAP, STOP);
        else n_pass++;
        CYCLE  = 15'd3;
        IDX    = 15'd3;
        UPDATE = 1'b1;
        for (int w = 1; w <= 4; w++) begin
            step();
            exp_stop = (w >= 3);
            n_total++; if (STOP !== exp_stop)
                $display("FAIL loop_stop_wrap%0d: got %b want %b", w, STOP, exp_stop);
            else n_pass++;
        end
        UPDATE = 1'b0;
        // Same-segment request with REP=0: clears STOP, no swap, mode ignored.
        drive_req(1'b1, 3'd2, 64'd0, 16'd0);
        step();
        REQ_VALID = 1'b0;
        n_total++; if (STOP !== 1'b0 || SWAP !== 1'b0 || SEGMENT !== 1'b1 || PENDING !== 1'b0)
            $display("FAIL loop_same_seg: got stop=%b swap=%b seg=%b pend=%b want 0 0 1 0", STOP, SWAP, SEGMENT, PENDING);
        else n_pass++;
        UPDATE = 1'b1;
        step();
        UPDATE = 1'b0;
        n_total++; if (STOP !== 1'b1) $display("FAIL loop_rep0_stop: got %b want 1", STOP); else n_pass++;
    endtask

    // Segment 1 with STOP high: an invalid request must change nothing but ERR.
    task automatic test_invalid_mode();
        drive_req(1'b0, 3'd5, 64'd0, 16'hFFFF);
        step();
        REQ_VALID = 1'b0;
        n_total++; if (ERR !== 1'b1) $display("FAIL inv_err: got %b want 1", ERR); else n_pass++;
        n_total++; if (SEGMENT !== 1'b1 || SWAP !== 1'b0 || STOP !== 1'b1 || PENDING !== 1'b0)
            $display("FAIL inv_outputs: got seg=%b swap=%b stop=%b pend=%b want 1 0 1 0", SEGMENT, SWAP, STOP, PENDING);
        else n_pass++;
        step();
        n_total++; if (ERR !== 1'b0) $display("FAIL inv_err_end: got %b want 0", ERR); else n_pass++;
    endtask

    task automatic test_reset_in_wait();
        IDX   = 15'd0;
        CYCLE = 15'd9;
        drive_req(1'b0, 3'd1, 64'd0, 16'hFFFF);
        step();
        REQ_VALID = 1'b0;
        n_total++; if (PENDING !== 1'b1) $display("FAIL rw_pending: got %b want 1", PENDING); else n_pass++;
        RESET = 1'b1;
        step();
        n_total++; if (SEGMENT !== 1'b0 || PENDING !== 1'b0 || SWAP !== 1'b0 || STOP !== 1'b0)
            $display("FAIL rw_reset: got seg=%b pend=%b swap=%b stop=%b want 0 0 0 0", SEGMENT, PENDING, SWAP, STOP);
        else n_pass++;
        RESET = 1'b0;
        step();
        n_total++; if (REQ_READY !== 1'b1 || SWAP !== 1'b0 || SEGMENT !== 1'b0)
            $display("FAIL rw_after: got ready=%b swap=%b seg=%b want 1 0 0", REQ_READY, SWAP, SEGMENT);
        else n_pass++;
    endtask

    initial begin
        n_pass      = 0;
        n_total     = 0;
        RESET       = 1'b1;
        SYS_TIME    = 64'd0;
        UPDATE      = 1'b0;
        IDX         = '0;
        CYCLE       = 15'd9;
        GPIO_IN     = 4'b0000;
        REQ_VALID   = 1'b0;
        REQ_SEGMENT = 1'b0;
        REQ_MODE    = 3'd0;
        REQ_VALUE   = 64'd0;
        REQ_REP     = 16'hFFFF;
        #1;

        test_reset();
        test_immediate();
        test_sync_idx();
        test_sys_time();
        test_gpio();
        test_loop_stop();
        test_invalid_mode();
        test_reset_in_wait();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
